// File: rtl/spi_burst_reader_pkg.sv
// Shared types and widths for the SPI burst reader and its receive FIFO.
package spi_burst_reader_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    STORE,
    STALL
  } state_t;
endpackage

// File: rtl/spi_rx_fifo.sv
// First-word-fall-through receive FIFO; dout always shows the oldest entry.
module spi_rx_fifo
  import spi_burst_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        push,
  input  logic [DATA_W-1:0]           din,
  input  logic                        pop,
  output logic [DATA_W-1:0]           dout,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == (AW + 1)'(FIFO_DEPTH));
endmodule

// File: rtl/spi_burst_reader.sv
// Reads a burst of consecutive registers through the SPI driver into a receive FIFO.
//
// state     | meaning
// IDLE      | waiting for start
// ISSUE     | pulse new_command for the current address, or stall if FIFO full
// WAIT_DONE | waiting for driver completion edge, timeout counter running
// STORE     | push captured byte, advance address, finish or issue next
// STALL     | FIFO full, waiting for the consumer to pop
module spi_burst_reader
  import spi_burst_reader_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic                        abort,
  input  logic [ADDR_W-1:0]           start_addr,
  input  logic [7:0]                  num_words,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout_err,
  output logic [7:0]                  words_done,
  output logic                        new_command,
  output logic [ADDR_W-1:0]           register_addr,
  output logic [DATA_W-1:0]           write_data,
  input  logic                        transaction_complete,
  input  logic [DATA_W-1:0]           data_read_from_reg,
  input  logic                        fifo_rd_en,
  output logic [DATA_W-1:0]           fifo_dout,
  output logic                        fifo_empty,
  output logic                        fifo_full,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int              CW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]   WAIT_LOAD = CW'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [7:0]        num_latched;
  logic [CW-1:0]     wait_cnt;
  logic              tc_prev;
  logic              tc_rise;
  logic [DATA_W-1:0] rx_data;
  logic              store_push;

  assign write_data = '0;
  assign tc_rise    = transaction_complete && !tc_prev;
  assign store_push = (state == STORE) && !abort;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout_err   <= 1'b0;
      words_done    <= '0;
      new_command   <= 1'b0;
      register_addr <= '0;
      num_latched   <= '0;
      wait_cnt      <= '0;
      rx_data       <= '0;
      tc_prev       <= 1'b1;
    end else begin
      done        <= 1'b0;
      new_command <= 1'b0;
      tc_prev     <= transaction_complete;
      if (state != IDLE && abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              register_addr <= start_addr;
              num_latched   <= num_words;
              words_done    <= '0;
              timeout_err   <= 1'b0;
              if (num_words == 8'd0) begin
                done <= 1'b1;
              end else begin
                busy  <= 1'b1;
                state <= ISSUE;
              end
            end
          end
          ISSUE: begin
            if (fifo_full) begin
              state <= STALL;
            end else begin
              new_command <= 1'b1;
              wait_cnt    <= WAIT_LOAD;
              state       <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            if (tc_rise) begin
              rx_data <= data_read_from_reg;
              state   <= STORE;
            end else if (wait_cnt == '0) begin
              timeout_err <= 1'b1;
              done        <= 1'b1;
              busy        <= 1'b0;
              state       <= IDLE;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
          STORE: begin
            words_done    <= words_done + 8'd1;
            register_addr <= register_addr + 1'b1;
            // Final push and done land on the same clock edge.
            if (words_done + 8'd1 == num_latched) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= ISSUE;
            end
          end
          STALL: begin
            if (!fifo_full) state <= ISSUE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  spi_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (store_push),
    .din  (rx_data),
    .pop  (fifo_rd_en),
    .dout (fifo_dout),
    .empty(fifo_empty),
    .full (fifo_full),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_spi_burst_reader.sv
// Scoreboard bench: expected commands/bytes are queued at burst start, monitors pop and compare.
module tb_spi_burst_reader;
  localparam int         DEPTH = 4;
  localparam int         TMO   = 64;
  localparam logic [7:0] KEY   = 8'hA5;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] start_addr = '0;
  logic [7:0] num_words = '0;
  logic       busy, done, timeout_err;
  logic [7:0] words_done;
  logic       new_command;
  logic [7:0] register_addr, write_data;
  logic       transaction_complete = 1'b0;
  logic [7:0] data_read_from_reg = '0;
  logic       fifo_rd_en = 1'b0;
  logic [7:0] fifo_dout;
  logic       fifo_empty, fifo_full;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  spi_burst_reader #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .start_addr(start_addr), .num_words(num_words),
    .busy(busy), .done(done), .timeout_err(timeout_err), .words_done(words_done),
    .new_command(new_command), .register_addr(register_addr), .write_data(write_data),
    .transaction_complete(transaction_complete), .data_read_from_reg(data_read_from_reg),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .fifo_count(fifo_count)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] cmd_q[$];
  logic [7:0] data_q[$];
  int cmd_cnt = 0, done_cnt = 0, cyc = 0, cmd_cyc = 0, done_cyc = 0;
  bit drv_en = 1'b1;
  int drv_delay = 20;
  int drv_txn = 0;
  int pop_txn = 0;
  bit force_pop = 1'b0;
  bit rd_mode = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: commands, done pulses and FIFO pops are checked against the queues.
  always @(negedge clk) begin
    cyc++;
    if (rstn === 1'b1) begin
      if (new_command === 1'b1) begin
        cmd_cnt++;
        cmd_cyc = cyc;
        if (cmd_q.size() == 0) begin
          total++; bad++;
          $display("FAIL cmd_unexpected: got addr %0h want none", register_addr);
        end else chk("cmd_addr", register_addr, cmd_q.pop_front());
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (fifo_rd_en && fifo_empty === 1'b0) begin
        if (data_q.size() == 0) begin
          total++; bad++;
          $display("FAIL pop_unexpected: got %0h want none", fifo_dout);
        end else chk("fifo_data", fifo_dout, data_q.pop_front());
      end
    end
  end

  // Driver model: completes each command after drv_delay cycles, returning addr ^ KEY.
  initial begin
    logic [7:0] a;
    forever begin
      @(negedge clk);
      if (rstn && new_command === 1'b1 && drv_en) begin
        a = register_addr;
        drv_txn++;
        repeat (drv_delay) @(posedge clk);
        @(posedge clk); #1;
        transaction_complete = 1'b1;
        data_read_from_reg = a ^ KEY;
        @(posedge clk); #1;
        transaction_complete = 1'b0;
        if (pop_txn != 0 && drv_txn == pop_txn) begin
          chk("same_cycle_cnt_before", fifo_count, 2);
          force_pop = 1'b1;
          @(posedge clk); #1;
          force_pop = 1'b0;
          chk("same_cycle_cnt_after", fifo_count, 2);
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #2;
    fifo_rd_en = (rd_mode && ($urandom_range(0, 1) == 1)) || force_pop;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic start_burst(input logic [7:0] a, input int n, input bit exp);
    @(posedge clk); #1;
    if (exp) begin
      for (int i = 0; i < n; i++) begin
        cmd_q.push_back(8'(a + i));
        data_q.push_back(8'(a + i) ^ KEY);
      end
    end
    drv_txn = 0;
    start = 1'b1; start_addr = a; num_words = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    chk(nm, got, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_cmds(input int target, input string nm);
    for (int i = 0; i < 300 && cmd_cnt < target; i++) @(negedge clk);
    chk(nm, cmd_cnt >= target, 1);
  endtask

  task automatic drain(input string nm);
    rd_mode = 1'b1;
    for (int i = 0; i < 300 && !(fifo_empty && data_q.size() == 0); i++) @(negedge clk);
    rd_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk({nm, "_empty"}, fifo_empty, 1);
    chk({nm, "_data_left"}, data_q.size(), 0);
  endtask

  initial begin
    int d0, c0, n;
    logic [7:0] a;
    #3 rstn = 1'b0;
    #15;
    chk("rst_busy", busy, 0);          chk("rst_done", done, 0);
    chk("rst_tmo", timeout_err, 0);    chk("rst_words", words_done, 0);
    chk("rst_cmd", new_command, 0);    chk("rst_addr", register_addr, 0);
    chk("rst_wdata", write_data, 0);   chk("rst_count", fifo_count, 0);
    chk("rst_empty", fifo_empty, 1);   chk("rst_full", fifo_full, 0);
    #4 rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Basic burst of four, no consumer.
    drv_delay = 20; d0 = done_cnt;
    start_burst(8'h10, 4, 1'b1);
    chk("t1_busy", busy, 1);
    wait_done(400, "t1_done_seen");
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_words", words_done, 4);
    chk("t1_count", fifo_count, 4);
    chk("t1_full", fifo_full, 1);
    chk("t1_busy_end", busy, 0);
    chk("t1_head", fifo_dout, 8'hB5);
    chk("t1_cmd_left", cmd_q.size(), 0);
    drain("t1");

    // Address wrap with a random consumer.
    drv_delay = 3; rd_mode = 1'b1;
    start_burst(8'hFE, 3, 1'b1);
    wait_done(300, "t2_done_seen");
    chk("t2_words", words_done, 3);
    chk("t2_cmd_left", cmd_q.size(), 0);
    drain("t2");

    // Pop coincides with the third push while two entries are held.
    drv_delay = 5; pop_txn = 3;
    start_burst(8'h20, 3, 1'b1);
    wait_done(300, "t3_done_seen");
    pop_txn = 0;
    chk("t3_count", fifo_count, 2);
    drain("t3");

    // Stall on full FIFO, then resume after two pops.
    drv_delay = 2; c0 = cmd_cnt; d0 = done_cnt;
    start_burst(8'h30, 6, 1'b1);
    for (int i = 0; i < 200 && !fifo_full; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    chk("t4_stall_cmds", cmd_cnt - c0, 4);
    chk("t4_full", fifo_full, 1);
    chk("t4_words_stall", words_done, 4);
    chk("t4_busy_stall", busy, 1);
    @(posedge clk); #1 force_pop = 1'b1;
    repeat (2) @(posedge clk);
    #1 force_pop = 1'b0;
    wait_done(300, "t4_done_seen");
    chk("t4_count", fifo_count, 4);
    chk("t4_words", words_done, 6);
    chk("t4_cmds", cmd_cnt - c0, 6);
    chk("t4_done_cnt", done_cnt - d0, 1);
    drain("t4");

    // Driver never answers: timeout after TMO cycles in WAIT_DONE.
    drv_en = 1'b0; d0 = done_cnt;
    cmd_q.push_back(8'h40);
    start_burst(8'h40, 2, 1'b0);
    wait_done(300, "t5_done_seen");
    chk("t5_latency", done_cyc - cmd_cyc, TMO);
    chk("t5_tmo", timeout_err, 1);
    chk("t5_empty", fifo_empty, 1);
    chk("t5_words", words_done, 0);
    chk("t5_done_cnt", done_cnt - d0, 1);
    chk("t5_cmd_left", cmd_q.size(), 0);
    drv_en = 1'b1;

    // Abort while waiting on byte 2; its late completion must be dropped.
    drv_delay = 10; c0 = cmd_cnt; d0 = done_cnt;
    cmd_q.push_back(8'h80); cmd_q.push_back(8'h81);
    data_q.push_back(8'h80 ^ KEY);
    start_burst(8'h80, 4, 1'b0);
    chk("t6_tmo_cleared", timeout_err, 0);
    wait_cmds(c0 + 2, "t6_second_cmd");
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("t6_done_pulse", done, 1);
    chk("t6_busy", busy, 0);
    repeat (25) @(negedge clk);
    chk("t6_count", fifo_count, 1);
    chk("t6_words", words_done, 1);
    chk("t6_done_cnt", done_cnt - d0, 1);
    chk("t6_cmds", cmd_cnt - c0, 2);
    drain("t6");

    // Zero-length request.
    d0 = done_cnt; c0 = cmd_cnt;
    @(posedge clk); #1 start = 1'b1; start_addr = 8'h55; num_words = 8'd0;
    @(posedge clk); #1 start = 1'b0;
    chk("t7_done", done, 1);
    chk("t7_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("t7_done_cnt", done_cnt - d0, 1);
    chk("t7_cmds", cmd_cnt - c0, 0);

    // Random bursts with a random consumer and ignored starts while busy.
    for (int it = 0; it < 8; it++) begin
      a = 8'($urandom);
      n = $urandom_range(1, 10);
      drv_delay = $urandom_range(0, 6);
      rd_mode = 1'b1; d0 = done_cnt;
      start_burst(a, n, 1'b1);
      repeat ($urandom_range(1, 8)) @(negedge clk);
      if (busy) begin
        start = 1'b1; start_addr = ~a; num_words = 8'd9;
        @(posedge clk); #1 start = 1'b0;
      end
      wait_done(3000, "rnd_done_seen");
      chk("rnd_words", words_done, n);
      chk("rnd_done_cnt", done_cnt - d0, 1);
      chk("rnd_cmd_left", cmd_q.size(), 0);
      drain("rnd");
    end

    // Reset mid-burst discards everything without a done pulse.
    drv_delay = 4; c0 = cmd_cnt;
    start_burst(8'h60, 4, 1'b1);
    wait_cmds(c0 + 2, "t9_second_cmd");
    @(negedge clk);
    d0 = done_cnt;
    #2 rstn = 1'b0;
    #1;
    chk("t9_busy", busy, 0);          chk("t9_done", done, 0);
    chk("t9_tmo", timeout_err, 0);    chk("t9_words", words_done, 0);
    chk("t9_cmd", new_command, 0);    chk("t9_addr", register_addr, 0);
    chk("t9_wdata", write_data, 0);   chk("t9_count", fifo_count, 0);
    chk("t9_empty", fifo_empty, 1);   chk("t9_full", fifo_full, 0);
    cmd_q.delete();
    data_q.delete();
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("t9_no_done", done_cnt - d0, 0);
    chk("t9_still_empty", fifo_empty, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
